// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: transfer owner encoding and
// conflict counter sizing.
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_INST = 2'd1,
        OWNER_DATA = 2'd2
    } owner_t;

    localparam int CONFLICT_CNT_W = 16;
    localparam logic [CONFLICT_CNT_W-1:0] CONFLICT_CNT_MAX = '1;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one synchronous single-port SRAM between an instruction and a data requester.
// Define SRAM_ARB_RR_EN for round-robin conflict resolution; otherwise data always wins.
module sram_arbiter
    import sram_arbiter_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inst_req,
    input  logic [31:0]               inst_addr,
    output logic                      inst_addr_ok,
    output logic                      inst_data_ok,
    output logic [31:0]               inst_rdata,
    input  logic                      data_req,
    input  logic                      data_wr,
    input  logic [3:0]                data_wstrb,
    input  logic [31:0]               data_addr,
    input  logic [31:0]               data_wdata,
    output logic                      data_addr_ok,
    output logic                      data_data_ok,
    output logic [31:0]               data_rdata,
    output logic                      mem_en,
    output logic [3:0]                mem_wen,
    output logic [31:0]               mem_addr,
    output logic [31:0]               mem_wdata,
    input  logic [31:0]               mem_rdata,
    output logic [CONFLICT_CNT_W-1:0] conflict_cnt
);

    owner_t                    owner_q;
    owner_t                    owner_d;
    logic                      grant_inst;
    logic                      grant_data;
    logic                      data_wins;
    logic                      conflict;
    logic [CONFLICT_CNT_W-1:0] conflict_cnt_q;

    assign conflict = inst_req & data_req;

`ifdef SRAM_ARB_RR_EN
    // Pointer hands the next conflict to whichever side lost the last one.
    logic favour_data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            favour_data_q <= 1'b1;
        end else if (conflict) begin
            favour_data_q <= ~grant_data;
        end
    end

    assign data_wins = favour_data_q;
`else
    assign data_wins = 1'b1;
`endif

    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        mem_en     = 1'b0;
        mem_wen    = 4'b0000;
        mem_addr   = 32'h0;
        mem_wdata  = 32'h0;
        owner_d    = OWNER_NONE;

        if (!reset) begin
            if (data_req && (!inst_req || data_wins)) begin
                grant_data = 1'b1;
            end else if (inst_req) begin
                grant_inst = 1'b1;
            end
        end

        if (grant_data) begin
            mem_en    = 1'b1;
            mem_wen   = data_wr ? data_wstrb : 4'b0000;
            mem_addr  = data_addr;
            mem_wdata = data_wdata;
            owner_d   = OWNER_DATA;
        end else if (grant_inst) begin
            mem_en    = 1'b1;
            mem_addr  = inst_addr;
            owner_d   = OWNER_INST;
        end
    end

    // Owner of the transfer launched this cycle selects which data_ok fires next cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q <= OWNER_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt_q <= '0;
        end else if (conflict && (conflict_cnt_q != CONFLICT_CNT_MAX)) begin
            conflict_cnt_q <= conflict_cnt_q + 1'b1;
        end
    end

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;
    assign inst_data_ok = (owner_q == OWNER_INST);
    assign data_data_ok = (owner_q == OWNER_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;
    assign conflict_cnt = conflict_cnt_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: a rule-level model predicts grants and
// completions, a monitor pops expected completions as data_ok appears.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_en;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic [15:0] conflict_cnt;

    typedef struct {
        int          due;
        bit          is_data;
        bit          is_write;
        logic [31:0] addr;
    } xfer_t;

    xfer_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    bit    m_favour_data = 1'b1;
    int    m_cnt = 0;

    sram_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_wstrb   (data_wstrb),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .mem_en       (mem_en),
        .mem_wen      (mem_wen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM stand-in: every address reads back a fixed, address-derived word one cycle later.
    function automatic logic [31:0] sram_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
    endfunction

    always @(posedge clk) begin
        if (mem_en) mem_rdata <= sram_word(mem_addr);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic checkZero();
        checkOutput("rst_inst_addr_ok", inst_addr_ok, 0);
        checkOutput("rst_data_addr_ok", data_addr_ok, 0);
        checkOutput("rst_inst_data_ok", inst_data_ok, 0);
        checkOutput("rst_data_data_ok", data_data_ok, 0);
        checkOutput("rst_mem_en", mem_en, 0);
        checkOutput("rst_mem_wen", mem_wen, 0);
        checkOutput("rst_conflict_cnt", conflict_cnt, 0);
    endtask

    task automatic clearModel();
        sb_q.delete();
        m_favour_data = 1'b1;
        m_cnt = 0;
    endtask

    // Reset is held with both requests pending to show that nothing leaks out.
    task automatic resetBlock(input int cycles);
        @(negedge clk);
        #3;
        reset = 1'b1;
        inst_req = 1'b1;
        data_req = 1'b1;
        clearModel();
        repeat (cycles) begin
            @(negedge clk);
            #1;
            checkZero();
        end
        inst_req = 1'b0;
        data_req = 1'b0;
        reset = 1'b0;
    endtask

    task automatic applyStimulus(
        input  bit          ireq,
        input  logic [31:0] iaddr,
        input  bit          dreq,
        input  bit          dwr,
        input  logic [3:0]  dstrb,
        input  logic [31:0] daddr,
        input  logic [31:0] dwdata,
        input  bit          abort,
        output bit          ig,
        output bit          dg,
        output bit          dut_ig,
        output bit          dut_dg
    );
        xfer_t x;
        @(negedge clk);
        inst_req   = ireq;
        inst_addr  = iaddr;
        data_req   = dreq;
        data_wr    = dwr;
        data_wstrb = dstrb;
        data_addr  = daddr;
        data_wdata = dwdata;
        dg = dreq && (!ireq || m_favour_data);
        ig = ireq && !dg;
        #1;
        dut_ig = inst_addr_ok;
        dut_dg = data_addr_ok;
        checkOutput("conflict_cnt", conflict_cnt, 32'(m_cnt));
        checkOutput("inst_addr_ok", inst_addr_ok, ig);
        checkOutput("data_addr_ok", data_addr_ok, dg);
        checkOutput("mem_en", mem_en, ig | dg);
        checkOutput("mem_wen", mem_wen, (dg && dwr) ? dstrb : 4'b0000);
        if (ig || dg) checkOutput("mem_addr", mem_addr, dg ? daddr : iaddr);
        if (dg && dwr) checkOutput("mem_wdata", mem_wdata, dwdata);
        if (abort) begin
            #2;
            reset = 1'b1;
            clearModel();
            #1;
            checkZero();
            return;
        end
        if (ireq && dreq) begin
            if (m_cnt < 65535) m_cnt++;
`ifdef SRAM_ARB_RR_EN
            m_favour_data = !dg;
`endif
        end
        if (ig || dg) begin
            x.due      = cyc + 1;
            x.is_data  = dg;
            x.is_write = dg && dwr;
            x.addr     = dg ? daddr : iaddr;
            sb_q.push_back(x);
        end
    endtask

    // Monitor: every cycle, data_ok must match the head of the scoreboard.
    initial begin
        bit exp_i;
        bit exp_d;
        xfer_t x;
        forever begin
            @(negedge clk);
            #2;
            if (reset) continue;
            exp_i = (sb_q.size() > 0) && (sb_q[0].due == cyc) && !sb_q[0].is_data;
            exp_d = (sb_q.size() > 0) && (sb_q[0].due == cyc) && sb_q[0].is_data;
            checkOutput("inst_data_ok", inst_data_ok, exp_i);
            checkOutput("data_data_ok", data_data_ok, exp_d);
            if (exp_i || exp_d) begin
                x = sb_q.pop_front();
                if (exp_i) checkOutput("inst_rdata", inst_rdata, sram_word(x.addr));
                else if (!x.is_write) checkOutput("data_rdata", data_rdata, sram_word(x.addr));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: run did not complete, %0d checks so far", n_checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit gi, gd, ai, ad;
        bit ip, dp, dwr_r;
        logic [31:0] ia, da, dwd;
        logic [3:0] ds;
        bit seq_d[4];

        reset = 1'b1;
        inst_req = 1'b0;
        inst_addr = 32'h0;
        data_req = 1'b0;
        data_wr = 1'b0;
        data_wstrb = 4'h0;
        data_addr = 32'h0;
        data_wdata = 32'h0;
        resetBlock(2);

        // Four-cycle conflict straight out of reset.
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 32'h0000_1000 + 32'(k * 4), 1, 0, 4'h0, 32'h0000_2000 + 32'(k * 4), 32'h0, 0, gi, gd, ai, ad);
            seq_d[k] = ad;
        end
`ifdef SRAM_ARB_RR_EN
        checkOutput("conflict_seq0", seq_d[0], 1);
        checkOutput("conflict_seq1", seq_d[1], 0);
        checkOutput("conflict_seq2", seq_d[2], 1);
        checkOutput("conflict_seq3", seq_d[3], 0);
`else
        for (int k = 0; k < 4; k++) checkOutput("conflict_seq_data", seq_d[k], 1);
`endif
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd, ai, ad);
        checkOutput("conflict_cnt_4", conflict_cnt, 4);

        applyStimulus(1, 32'hBFC0_0000, 0, 0, 4'h0, 0, 0, 0, gi, gd, ai, ad);
        checkOutput("inst_only_grant", ai, 1);

        applyStimulus(0, 0, 1, 1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF, 0, gi, gd, ai, ad);
        checkOutput("data_write_grant", ad, 1);

        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 32'hBFC0_0010 + 32'(k * 4), 0, 0, 4'h0, 0, 0, 0, gi, gd, ai, ad);
            checkOutput("b2b_inst_grant", ai, 1);
        end
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd, ai, ad);

        // Data read accepted in the same cycle reset rises: completion must be dropped.
        applyStimulus(0, 0, 1, 0, 4'h0, 32'h0000_0200, 0, 1, gi, gd, ai, ad);
        checkOutput("abort_grant", ad, 1);
        resetBlock(2);
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd, ai, ad);
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd, ai, ad);

        ip = 0;
        dp = 0;
        ia = 0; da = 0; dwd = 0; ds = 0; dwr_r = 0;
        for (int k = 0; k < 400; k++) begin
            if (!ip && ($urandom_range(2) != 0)) begin
                ip = 1;
                ia = $urandom & 32'hFFFF_FFFC;
            end
            if (!dp && ($urandom_range(2) != 0)) begin
                dp = 1;
                dwr_r = 1'($urandom_range(1));
                ds = 4'($urandom_range(15));
                da = $urandom;
                dwd = $urandom;
            end
            applyStimulus(ip, ia, dp, dwr_r, ds, da, dwd, 0, gi, gd, ai, ad);
            if (gi) ip = 0;
            if (gd) dp = 0;
        end

        // Long conflict drives the counter into saturation.
        resetBlock(1);
        for (int k = 0; k < 65540; k++) begin
            applyStimulus(1, 32'h0000_4000, 1, 0, 4'h0, 32'h0000_8000, 0, 0, gi, gd, ai, ad);
        end
        applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd, ai, ad);
        checkOutput("conflict_cnt_sat", conflict_cnt, 32'h0000_FFFF);

        repeat (3) applyStimulus(0, 0, 0, 0, 4'h0, 0, 0, 0, gi, gd, ai, ad);
        checkOutput("scoreboard_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  instruction read request.
- inst_addr  in  32  instruction byte address.
- inst_addr_ok  out  1  instruction request accepted this cycle.
- inst_data_ok  out  1  instruction read data valid this cycle.
- inst_rdata  out  32  instruction read data.
- data_req  in  1  data request.
- data_wr  in  1  1 = write, 0 = read.
- data_wstrb  in  4  byte write strobes.
- data_addr  in  32  data byte address.
- data_wdata  in  32  write data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data read data valid, or write complete, this cycle.
- data_rdata  out  32  data read data.
- mem_en  out  1  shared SRAM enable.
- mem_wen  out  4  shared SRAM byte write enables.
- mem_addr  out  32  shared SRAM address.
- mem_wdata  out  32  shared SRAM write data.
- mem_rdata  in  32  shared SRAM read data, valid one cycle after mem_en.
- conflict_cnt  out  16  count of cycles in which both requesters were pending.

Function
REQ-002 The block SHALL arbitrate one synchronous single-port SRAM between the instruction requester and the data requester, granting at most one request per cycle.
REQ-003 A grant SHALL be combinational in the request cycle N: addr_ok=1 for the winner, mem_en=1, and mem_addr/mem_wdata driven from the winner.
REQ-004 mem_wen SHALL equal data_wstrb for a data write grant and 4'b0000 otherwise; an instruction grant never writes.
REQ-005 The block SHALL hold an owner register (NONE/INST/DATA) written at the end of cycle N; in cycle N+1 exactly one of inst_data_ok or data_data_ok SHALL pulse for one cycle, selected by owner.
REQ-006 inst_rdata and data_rdata SHALL both pass mem_rdata through; each is meaningful only while its data_ok is high.
REQ-007 Data writes SHALL also return data_ok in N+1; data_rdata is then don't-care.
REQ-008 A new grant SHALL be allowed in the same cycle as a data_ok, giving a sustained throughput of one transfer per cycle.
REQ-009 A requester without a grant SHALL see addr_ok=0 and SHALL hold its request stable until accepted.
REQ-010 When no request is pending: mem_en=0, mem_wen=0, and owner SHALL become NONE.
REQ-011 Priority when both requests are pending SHALL follow REQ-016/REQ-017.
REQ-012 conflict_cnt SHALL increment in every cycle with inst_req=1 and data_req=1, and SHALL saturate at 16'hFFFF.

Reset
REQ-013 While reset=1: owner=NONE, all *_addr_ok, *_data_ok, mem_en and mem_wen are 0, conflict_cnt=0, and the round-robin pointer is set to favour DATA.
REQ-014 A transfer accepted in the cycle reset asserts SHALL be dropped: no data_ok is produced after reset.
REQ-015 Grants SHALL resume in the first cycle after reset deasserts.

Configuration
REQ-016 Without SRAM_ARB_RR_EN defined, DATA SHALL always win a conflict.
REQ-017 With SRAM_ARB_RR_EN defined:
- a 1-bit pointer SHALL select the conflict winner;
- the pointer SHALL flip to the loser after each conflict grant;
- a non-conflict grant SHALL leave the pointer unchanged.

Structure
REQ-018 A shared package SHALL hold the owner encoding (NONE=2'd0, INST=2'd1, DATA=2'd2) and the conflict counter width constant (16).
REQ-019 The block SHALL be implemented as a single module with no sub-modules.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Instruction read only: inst_req, inst_addr=0xBFC00000 -> inst_addr_ok same cycle; inst_data_ok next cycle with inst_rdata=mem_rdata.
- Data write: data_wr=1, data_wstrb=4'b0011, data_addr=0x100, data_wdata=0xDEADBEEF -> mem_wen=4'b0011 same cycle; data_data_ok next cycle; inst_data_ok stays 0.
- Both requests for 4 cycles, default build -> data granted all 4 cycles; conflict_cnt=4.
- Both requests for 4 cycles, SRAM_ARB_RR_EN build -> grants DATA, INST, DATA, INST.
- Back-to-back instruction reads over 3 cycles -> addr_ok asserted 3 consecutive cycles; data_ok asserted 3 consecutive cycles, each one cycle later.
- Reset asserted in the accept cycle of a data read -> no data_data_ok afterwards; all outputs 0 while reset is high.
- Conflict held for 65540 cycles -> conflict_cnt holds at 16'hFFFF.
